ascii_time_decoder: RTL and testbench

Receive-side command decoder for the UART/FIFO path: it pops ASCII bytes from the RX FIFO and converts digit characters back to 4-bit values, the inverse of the TX-side digit-to-ASCII encoding. It parses single-letter key commands and a time-set command ("S" + HHMMSS + CR/LF). It drives the digital clock core with one-cycle key pulses and a validated hour/min/sec load. An inter-character timeout aborts stalled commands.

---
 rtl/ascii_time_decoder.sv | 144 ++++++++++++++
 tb/tb_ascii_time_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ascii_time_decoder.sv
// RX-side command decoder: pops ASCII bytes from a FWFT FIFO and turns them into
// key pulses ("r/l/u/d") or a validated time load ("S" HHMMSS CR/LF).
module ascii_time_decoder #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRxEmpty,
    input  logic [7:0] iRxData,
    output logic       oRxPop,
    output logic [3:0] oKey,
    output logic       oSetValid,
    output logic [4:0] oHour,
    output logic [5:0] oMin,
    output logic [5:0] oSec,
    output logic       oErr
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_SP = 8'h20;

    typedef enum logic [1:0] {IDLE, DIGIT, TERM} state_t;

    state_t           state;
    logic [2:0]       digitCnt;
    logic [3:0]       digits [6];
    logic [CNT_W-1:0] timeoutCnt;

    logic [7:0] chr;
    logic       isDigit;
    logic [3:0] nibble;
    logic [6:0] hourBin;
    logic [6:0] minBin;
    logic [6:0] secBin;
    logic       rangeOk;

    // The decoder never back-pressures: every available byte is taken.
    assign oRxPop = !iRxEmpty && !iRst;

    assign chr = ((iRxData >= 8'h41 && iRxData <= 8'h5A) ||
                  (iRxData >= 8'h61 && iRxData <= 8'h7A)) ? (iRxData | 8'h20) : iRxData;

    assign isDigit = (iRxData >= 8'h30) && (iRxData <= 8'h39);
    assign nibble  = iRxData[3:0];

    // Tens digits can reach 9, so the intermediate values need 7 bits.
    assign hourBin = {3'b000, digits[0]} * 7'd10 + {3'b000, digits[1]};
    assign minBin  = {3'b000, digits[2]} * 7'd10 + {3'b000, digits[3]};
    assign secBin  = {3'b000, digits[4]} * 7'd10 + {3'b000, digits[5]};
    assign rangeOk = (hourBin <= 7'd23) && (digits[2] <= 4'd5) && (digits[4] <= 4'd5);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            digitCnt   <= '0;
            timeoutCnt <= '0;
            oKey       <= '0;
            oSetValid  <= 1'b0;
            oErr       <= 1'b0;
            oHour      <= '0;
            oMin       <= '0;
            oSec       <= '0;
            // NOTE: the digit slots are a handful of flops, not a RAM, so resetting
            // them is cheap and keeps simulation free of X.
            for (int i = 0; i < 6; i++) digits[i] <= '0;
        end else begin
            oKey      <= '0;
            oSetValid <= 1'b0;
            oErr      <= 1'b0;

            if (oRxPop) begin
                timeoutCnt <= '0;
                case (state)
                    IDLE: begin
                        case (chr)
                            "r":    oKey <= 4'b0001;
                            "l":    oKey <= 4'b0010;
                            "u":    oKey <= 4'b0100;
                            "d":    oKey <= 4'b1000;
                            "s": begin
                                state    <= DIGIT;
                                digitCnt <= '0;
                                for (int i = 0; i < 6; i++) digits[i] <= '0;
                            end
                            CHR_CR, CHR_LF, CHR_SP: ;
                            default: oErr <= 1'b1;
                        endcase
                    end
                    DIGIT: begin
                        if (isDigit) begin
                            digits[digitCnt] <= nibble;
                            digitCnt         <= digitCnt + 3'd1;
                            if (digitCnt == 3'd5) state <= TERM;
                        end else if (chr == "s") begin
                            digitCnt <= '0;
                            for (int i = 0; i < 6; i++) digits[i] <= '0;
                        end else begin
                            oErr  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    TERM: begin
                        if (chr == CHR_CR || chr == CHR_LF) begin
                            if (rangeOk) begin
                                oHour     <= hourBin[4:0];
                                oMin      <= minBin[5:0];
                                oSec      <= secBin[5:0];
                                oSetValid <= 1'b1;
                            end else begin
                                oErr <= 1'b1;
                            end
                            state <= IDLE;
                        end else if (chr == "s") begin
                            state    <= DIGIT;
                            digitCnt <= '0;
                            for (int i = 0; i < 6; i++) digits[i] <= '0;
                        end else begin
                            oErr  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                timeoutCnt <= '0;
            end else if (timeoutCnt == CNT_LAST) begin
                // Stalled command: abort and drop whatever digits arrived.
                oErr       <= 1'b1;
                state      <= IDLE;
                digitCnt   <= '0;
                timeoutCnt <= '0;
            end else begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ascii_time_decoder.sv
// Directed bench for ascii_time_decoder: key commands, time-set, range errors,
// restarts, inter-character timeout and mid-command reset.
module tb_ascii_time_decoder;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iRxEmpty;
    logic [7:0] iRxData;
    logic       oRxPop;
    logic [3:0] oKey;
    logic       oSetValid;
    logic [4:0] oHour;
    logic [5:0] oMin;
    logic [5:0] oSec;
    logic       oErr;

    int checkCnt = 0;
    int failCnt  = 0;

    // Pulse tallies, accumulated once per clock by the drive tasks.
    int errSeen;
    int setSeen;
    int keySeen;

    ascii_time_decoder #(.TIMEOUT_CYC(16)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iRxEmpty (iRxEmpty),
        .iRxData  (iRxData),
        .oRxPop   (oRxPop),
        .oKey     (oKey),
        .oSetValid(oSetValid),
        .oHour    (oHour),
        .oMin     (oMin),
        .oSec     (oSec),
        .oErr     (oErr)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            failCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearTally();
        errSeen = 0;
        setSeen = 0;
        keySeen = 0;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        errSeen += int'(oErr);
        setSeen += int'(oSetValid);
        keySeen += int'(oKey != 4'b0000);
    endtask

    task automatic idle(input int n);
        iRxEmpty = 1'b1;
        repeat (n) tick();
    endtask

    // Byte is consumed on the next edge; outputs it triggers are visible on return.
    task automatic sendByte(input logic [7:0] b);
        iRxData  = b;
        iRxEmpty = 1'b0;
        tick();
        iRxEmpty = 1'b1;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    initial begin
        iRst     = 1'b1;
        iRxEmpty = 1'b0;
        iRxData  = "r";
        clearTally();

        // Reset with a byte waiting: pop suppressed, byte kept for after reset.
        repeat (2) @(posedge iClk);
        #1;
        check("pop_in_reset", oRxPop, 0);
        check("rst_key", oKey, 0);
        check("rst_set", oSetValid, 0);
        check("rst_err", oErr, 0);
        check("rst_time", {oHour, oMin, oSec}, 0);
        iRst = 1'b0;
        #1;
        check("pop_after_reset", oRxPop, 1);
        tick();
        check("held_byte_key_r", oKey, 4'b0001);
        iRxEmpty = 1'b1;
        idle(1);

        // Full time set, back to back.
        clearTally();
        sendStr("S123456");
        check("no_set_before_cr", setSeen, 0);
        sendByte(8'h0D);
        check("set_valid", oSetValid, 1);
        check("hour_12", oHour, 12);
        check("min_34", oMin, 34);
        check("sec_56", oSec, 56);
        idle(1);
        check("set_one_cycle", oSetValid, 0);
        check("set_no_err", errSeen, 0);

        // Key commands with case folding.
        clearTally();
        sendByte("r"); check("key_r", oKey, 4'b0001);
        sendByte("L"); check("key_L", oKey, 4'b0010);
        sendByte("u"); check("key_u", oKey, 4'b0100);
        sendByte("D"); check("key_D", oKey, 4'b1000);
        idle(1);
        check("key_clear", oKey, 0);
        check("key_no_err", errSeen, 0);

        // Range errors keep the held time.
        clearTally();
        sendStr("S245959"); sendByte(8'h0A);
        check("hour24_err", oErr, 1);
        sendStr("S236060"); sendByte(8'h0A);
        check("min60_err", oErr, 1);
        idle(1);
        check("range_err_count", errSeen, 2);
        check("range_no_set", setSeen, 0);
        check("range_hold", {oHour, oMin, oSec}, {5'd12, 6'd34, 6'd56});

        // Protocol error in DIGIT, then IDLE decoding resumes.
        clearTally();
        sendStr("S12x");
        check("bad_digit_err", oErr, 1);
        sendByte("u");
        check("idle_after_err", oKey, 4'b0100);
        check("bad_digit_err_count", errSeen, 1);

        // Restart mid-command.
        clearTally();
        sendStr("S12S000000"); sendByte(8'h0D);
        check("restart_set", oSetValid, 1);
        check("restart_time", {oHour, oMin, oSec}, 0);
        check("restart_no_err", errSeen, 0);
        check("restart_one_set", setSeen, 1);

        // Unknown byte in IDLE, stray digit in TERM.
        clearTally();
        sendByte("z");
        check("idle_unknown_err", oErr, 1);
        sendStr("S1234567");
        check("term_digit_err", oErr, 1);
        idle(1);
        check("misc_err_count", errSeen, 2);

        // Timeout: oErr exactly 16 cycles after the last pop.
        clearTally();
        sendStr("S12");
        idle(15);
        check("timeout_not_early", errSeen, 0);
        idle(1);
        check("timeout_err", oErr, 1);
        clearTally();
        sendByte(8'h0D);
        check("cr_after_timeout_silent", errSeen + setSeen + keySeen, 0);

        // Pop on the timeout cycle wins.
        clearTally();
        sendStr("S12");
        idle(15);
        sendStr("3456"); sendByte(8'h0D);
        check("pop_wins_set", oSetValid, 1);
        check("pop_wins_time", {oHour, oMin, oSec}, {5'd12, 6'd34, 6'd56});
        check("pop_wins_no_err", errSeen, 0);

        // Reset mid-command.
        sendStr("S1234");
        iRst = 1'b1;
        idle(1);
        iRst = 1'b0;
        check("midrst_time", {oHour, oMin, oSec}, 0);
        check("midrst_pulses", {oKey, oSetValid, oErr}, 0);
        clearTally();
        sendStr("S000001"); sendByte(8'h0D);
        check("after_rst_set", oSetValid, 1);
        check("after_rst_sec", oSec, 1);
        check("after_rst_no_err", errSeen, 0);

        // Whitespace in IDLE is ignored.
        clearTally();
        sendByte(8'h0D); sendByte(8'h0A); sendByte(8'h20);
        idle(1);
        check("whitespace_silent", errSeen + setSeen + keySeen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
